ct_lsu_pfu_mmu_arb: RTL

CT_LSU_PFU_MMU_ARB -- requirements
Module: ct_lsu_pfu_mmu_arb

---
 rtl/ct_lsu_pfu_mmu_arb.sv | 101 ++++++++++
 1 files changed

// File: rtl/ct_lsu_pfu_mmu_arb.sv
// ct_lsu_pfu_mmu_arb: arbitrates GPFB prefetch translation requests onto the MMU port.
// Define CT_LSU_PFU_MMU_TIMEOUT_EN to abandon a REQ after 256 cycles without an MMU grant (error response).
module ct_lsu_pfu_mmu_arb (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        cp0_lsu_pfu_mmu_dis,
  input  logic        pfu_pop_all_vld,
  input  logic        pfu_gpfb_mmu_pe_req,
  input  logic [1:0]  pfu_gpfb_mmu_pe_req_src,
  input  logic [27:0] pfu_gpfb_l1_vpn,
  input  logic [27:0] pfu_gpfb_l2_vpn,
  output logic        pfu_gpfb_mmu_pe_req_grnt,
  output logic        pfu_mmu_pe_req_sel_l1,
  output logic        pfu_get_ppn_vld,
  output logic [27:0] pfu_get_ppn,
  output logic        pfu_get_ppn_err,
  output logic        pfu_get_page_sec,
  output logic        pfu_get_page_share,
  output logic        pfu_mmu_va_vld,
  output logic [27:0] pfu_mmu_vpn,
  input  logic        mmu_pfu_req_grnt,
  input  logic        mmu_pfu_pa_vld,
  input  logic [27:0] mmu_pfu_ppn,
  input  logic        mmu_pfu_pa_err,
  input  logic        mmu_pfu_sec,
  input  logic        mmu_pfu_share
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_e;
  state_e      state_q, state_d;
  logic        abort, grnt, va_vld, rsp_take, tmo;
  logic        sel_l1_q, err_q, sec_q, share_q, ppn_vld_q;
  logic [27:0] vpn_q, ppn_q;
  logic        unused_src;
  assign unused_src = pfu_gpfb_mmu_pe_req_src[1];
  assign abort = pfu_pop_all_vld | cp0_lsu_pfu_mmu_dis;
`ifdef CT_LSU_PFU_MMU_TIMEOUT_EN
  logic [7:0] cnt_q;
  // cleared outside REQ, so it reads 0 on the first REQ cycle
  always_ff @(posedge forever_cpuclk or posedge cpurst_b)
    if (cpurst_b) cnt_q <= '0;
    else cnt_q <= (state_q == REQ) ? cnt_q + 8'd1 : 8'd0;
  assign tmo = state_q == REQ && cnt_q == 8'hff && !mmu_pfu_req_grnt && !abort;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge forever_cpuclk or posedge cpurst_b)
    if (cpurst_b) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = grnt ? REQ : IDLE;
      REQ:     state_d = abort ? (mmu_pfu_req_grnt ? FLUSH : IDLE)
                       : mmu_pfu_req_grnt ? WAIT : tmo ? IDLE : REQ;
      WAIT:    state_d = mmu_pfu_pa_vld ? IDLE : pfu_pop_all_vld ? FLUSH : WAIT;
      FLUSH:   state_d = mmu_pfu_pa_vld ? IDLE : FLUSH;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    grnt     = state_q == IDLE && pfu_gpfb_mmu_pe_req && !abort;
    va_vld   = state_q == REQ && !abort;
    rsp_take = state_q == WAIT && mmu_pfu_pa_vld && !pfu_pop_all_vld;
  end
  always_ff @(posedge forever_cpuclk or posedge cpurst_b)
    if (cpurst_b) begin
      sel_l1_q  <= 1'b0;
      vpn_q     <= '0;
      ppn_vld_q <= 1'b0;
      ppn_q     <= '0;
      err_q     <= 1'b0;
      sec_q     <= 1'b0;
      share_q   <= 1'b0;
    end else begin
      ppn_vld_q <= rsp_take | tmo;
      if (grnt) begin
        sel_l1_q <= pfu_gpfb_mmu_pe_req_src[0];
        vpn_q    <= pfu_gpfb_mmu_pe_req_src[0] ? pfu_gpfb_l1_vpn : pfu_gpfb_l2_vpn;
      end
      if (rsp_take) begin
        ppn_q   <= mmu_pfu_ppn;
        err_q   <= mmu_pfu_pa_err;
        sec_q   <= mmu_pfu_sec;
        share_q <= mmu_pfu_share;
      end else if (tmo) begin
        ppn_q   <= '0;
        err_q   <= 1'b1;
        sec_q   <= 1'b0;
        share_q <= 1'b0;
      end
    end
  assign pfu_gpfb_mmu_pe_req_grnt = grnt;
  assign pfu_mmu_pe_req_sel_l1    = sel_l1_q;
  assign pfu_mmu_va_vld           = va_vld;
  assign pfu_mmu_vpn              = vpn_q;
  assign pfu_get_ppn_vld          = ppn_vld_q;
  assign pfu_get_ppn              = ppn_q;
  assign pfu_get_ppn_err          = err_q;
  assign pfu_get_page_sec         = sec_q;
  assign pfu_get_page_share       = share_q;
endmodule
